// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the raw quarter/dollar slot sensors.
// It emits one registered pulse per physical coin, rejects ambiguous coins, flags stuck
// sensors as a jam, and keeps saturating audit counts of accepted coins.
module coin_acceptor #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JAM_CYCLES      = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_sense,
  input  logic             d_sense,
  input  logic             jam_clear,
  output logic             Q_in,
  output logic             D_in,
  output logic             coin_reject,
  output logic             jam,
  output logic [CNT_W-1:0] quarter_cnt,
  output logic [CNT_W-1:0] dollar_cnt
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned JAM_W = $clog2(JAM_CYCLES + 1);

  localparam logic [1:0] PAT_NONE    = 2'b00;
  localparam logic [1:0] PAT_QUARTER = 2'b10;
  localparam logic [1:0] PAT_DOLLAR  = 2'b01;
  localparam logic [1:0] PAT_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUALIFY,
    S_EMIT,
    S_RELEASE,
    S_JAM
  } state_t;

  state_t             state, state_d;
  logic [SYNC_STAGES-1:0] q_sync, d_sync;
  logic [1:0]         pat;
  logic [1:0]         pat_q, pat_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [DEB_W-1:0]   rel_q, rel_d;
  logic [JAM_W-1:0]   jtmr_q, jtmr_d;

  // Metastability synchronisers for the asynchronous sensor levels
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sync <= '0;
      d_sync <= '0;
    end else begin
      q_sync <= {q_sync[SYNC_STAGES-2:0], q_sense};
      d_sync <= {d_sync[SYNC_STAGES-2:0], d_sense};
    end
  end

  assign pat = {q_sync[SYNC_STAGES-1], d_sync[SYNC_STAGES-1]};

  // State, latched pattern and timers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pat_q  <= PAT_NONE;
      deb_q  <= '0;
      rel_q  <= '0;
      jtmr_q <= '0;
    end else begin
      state  <= state_d;
      pat_q  <= pat_d;
      deb_q  <= deb_d;
      rel_q  <= rel_d;
      jtmr_q <= jtmr_d;
    end
  end

  // Next-state logic: qualify a stable pattern, emit once, then wait for a clean release
  always_comb begin
    state_d = state;
    pat_d   = pat_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    jtmr_d  = jtmr_q;
    unique case (state)
      S_IDLE: begin
        if (pat != PAT_NONE) begin
          pat_d   = pat;
          deb_d   = DEB_W'(1);
          state_d = S_QUALIFY;
        end
      end
      S_QUALIFY: begin
        if (pat == PAT_NONE) begin
          deb_d   = '0;
          state_d = S_IDLE;
        end else if (pat == pat_q) begin
          if (deb_q == DEB_W'(DEBOUNCE_CYCLES)) begin
            deb_d   = '0;
            state_d = S_EMIT;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end else begin
          // Sensors changed to another coin pattern: restart qualification on it
          pat_d = pat;
          deb_d = DEB_W'(1);
        end
      end
      S_EMIT: begin
        rel_d   = '0;
        jtmr_d  = '0;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        jtmr_d = jtmr_q + JAM_W'(1);
        if (pat == PAT_NONE && rel_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          rel_d   = '0;
          state_d = S_IDLE;
        end else if (jtmr_q == JAM_W'(JAM_CYCLES - 1)) begin
          rel_d   = '0;
          state_d = S_JAM;
        end else if (pat == PAT_NONE) begin
          rel_d = rel_q + DEB_W'(1);
        end else begin
          rel_d = '0;
        end
      end
      S_JAM: begin
        if (jam_clear && pat == PAT_NONE) begin
          jtmr_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered pulses, jam level and saturating audit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      Q_in        <= 1'b0;
      D_in        <= 1'b0;
      coin_reject <= 1'b0;
      jam         <= 1'b0;
      quarter_cnt <= '0;
      dollar_cnt  <= '0;
    end else begin
      Q_in        <= (state == S_EMIT) && (pat_q == PAT_QUARTER);
      D_in        <= (state == S_EMIT) && (pat_q == PAT_DOLLAR);
      coin_reject <= (state == S_EMIT) && (pat_q == PAT_INVALID);
      jam         <= (state_d == S_JAM);
      if (state == S_EMIT && pat_q == PAT_QUARTER && quarter_cnt != {CNT_W{1'b1}})
        quarter_cnt <= quarter_cnt + CNT_W'(1);
      if (state == S_EMIT && pat_q == PAT_DOLLAR && dollar_cnt != {CNT_W{1'b1}})
        dollar_cnt <= dollar_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: directed scenarios plus randomized coin/glitch traffic,
// checked against an event-level model of accepted coins and pulse timing.
module tb_coin_acceptor;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int JAM_CYCLES      = 1000;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        q_sense = 1'b0;
  logic        d_sense = 1'b0;
  logic        jam_clear = 1'b0;
  logic        Q_in, D_in, coin_reject, jam;
  logic [15:0] quarter_cnt, dollar_cnt;
  logic        s_Q_in, s_D_in, s_coin_reject, s_jam;
  logic [1:0]  s_quarter_cnt, s_dollar_cnt;

  int checks = 0;
  int errors = 0;
  int m_q = 0;
  int m_d = 0;

  coin_acceptor dut (
    .clk(clk), .rst(rst), .q_sense(q_sense), .d_sense(d_sense), .jam_clear(jam_clear),
    .Q_in(Q_in), .D_in(D_in), .coin_reject(coin_reject), .jam(jam),
    .quarter_cnt(quarter_cnt), .dollar_cnt(dollar_cnt)
  );

  coin_acceptor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .q_sense(q_sense), .d_sense(d_sense), .jam_clear(jam_clear),
    .Q_in(s_Q_in), .D_in(s_D_in), .coin_reject(s_coin_reject), .jam(s_jam),
    .quarter_cnt(s_quarter_cnt), .dollar_cnt(s_dollar_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected {Q_in,D_in,coin_reject} for an accepted coin with raw pattern {q,d}
  function automatic logic [2:0] onehot(input logic [1:0] p);
    case (p)
      2'b10:   return 3'b100;
      2'b01:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check_counts(input string tag);
    checks++;
    if (int'(quarter_cnt) !== sat(m_q, 16) || int'(dollar_cnt) !== sat(m_d, 16)) begin
      errors++;
      $display("FAIL %s counts got q=%0d d=%0d exp q=%0d d=%0d", tag, quarter_cnt, dollar_cnt,
               sat(m_q, 16), sat(m_d, 16));
    end
    checks++;
    if (int'(s_quarter_cnt) !== sat(m_q, 2) || int'(s_dollar_cnt) !== sat(m_d, 2)) begin
      errors++;
      $display("FAIL %s sat_counts got q=%0d d=%0d exp q=%0d d=%0d", tag, s_quarter_cnt,
               s_dollar_cnt, sat(m_q, 2), sat(m_d, 2));
    end
  endtask

  // Hold raw pattern for len cycles, then low for gap cycles; check pulses every cycle
  task automatic run_coin(input logic [1:0] pat, input int len, input int gap, input string tag);
    logic [2:0] exp_v, obs_v, obs_s;
    bit accepted;
    accepted = (len > DEBOUNCE_CYCLES) && (pat != 2'b00);
    for (int k = 0; k < len + gap; k++) begin
      @(negedge clk);
      q_sense = (k < len) ? pat[1] : 1'b0;
      d_sense = (k < len) ? pat[0] : 1'b0;
      @(posedge clk); #1;
      exp_v = (accepted && k == LAT) ? onehot(pat) : 3'b000;
      obs_v = {Q_in, D_in, coin_reject};
      obs_s = {s_Q_in, s_D_in, s_coin_reject};
      checks++;
      if (obs_v !== exp_v || obs_s !== exp_v) begin
        errors++;
        $display("FAIL %s pulse k=%0d got %b/%b exp %b", tag, k, obs_v, obs_s, exp_v);
      end
      checks++;
      if (jam !== 1'b0 || s_jam !== 1'b0) begin
        errors++;
        $display("FAIL %s jam k=%0d got %b/%b exp 0", tag, k, jam, s_jam);
      end
    end
    if (accepted && pat == 2'b10) m_q++;
    if (accepted && pat == 2'b01) m_d++;
    check_counts(tag);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; q_sense = 1'b0; d_sense = 1'b0; jam_clear = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    m_q = 0;
    m_d = 0;
    checks++;
    if ({Q_in, D_in, coin_reject, jam} !== 4'b0000 || {s_Q_in, s_D_in, s_coin_reject, s_jam} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b exp 0000", {Q_in, D_in, coin_reject, jam},
               {s_Q_in, s_D_in, s_coin_reject, s_jam});
    end
    check_counts("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3);
  endtask

  task automatic test_clean_quarter();
    run_coin(2'b10, 10, 12, "clean_quarter");
  endtask

  task automatic test_glitch();
    run_coin(2'b01, 3, 12, "glitch");
  endtask

  task automatic test_ambiguous();
    run_coin(2'b11, 8, 12, "ambiguous");
  endtask

  // Stuck quarter sensor: one Q_in, jam after JAM_CYCLES in release, clear only when released
  task automatic test_jam();
    logic [2:0] exp_v;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      q_sense   = 1'b1;
      jam_clear = (k == 500 || k == 1100);
      @(posedge clk); #1;
      exp_v = (k == LAT) ? 3'b100 : 3'b000;
      checks++;
      if ({Q_in, D_in, coin_reject} !== exp_v || {s_Q_in, s_D_in, s_coin_reject} !== exp_v) begin
        errors++;
        $display("FAIL jam_pulse k=%0d got %b exp %b", k, {Q_in, D_in, coin_reject}, exp_v);
      end
      if (k < LAT + JAM_CYCLES - 10 || k >= LAT + JAM_CYCLES + 10) begin
        checks++;
        if (jam !== (k >= LAT + JAM_CYCLES + 10) || s_jam !== jam) begin
          errors++;
          $display("FAIL jam_level k=%0d got %b/%b exp %b", k, jam, s_jam, k >= LAT + JAM_CYCLES + 10);
        end
      end
    end
    m_q++;
    check_counts("jam_hold");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      q_sense = 1'b0; jam_clear = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (jam !== 1'b1 || s_jam !== 1'b1) begin
        errors++;
        $display("FAIL jam_after_release k=%0d got %b/%b exp 1", k, jam, s_jam);
      end
    end
    @(negedge clk);
    jam_clear = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (jam !== 1'b0 || s_jam !== 1'b0) begin
      errors++;
      $display("FAIL jam_clear got %b/%b exp 0", jam, s_jam);
    end
    @(negedge clk);
    jam_clear = 1'b0;
    check_counts("jam_cleared");
    run_coin(2'b01, 8, 12, "jam_then_dollar");
  endtask

  // Reset while a quarter is qualifying (deb=2): no pulse, counts cleared, next coin normal
  task automatic test_reset_mid_qualify();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      q_sense = 1'b1;
      @(posedge clk); #1;
    end
    apply_reset(1);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({Q_in, D_in, coin_reject, jam} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid k=%0d got %b exp 0000", k, {Q_in, D_in, coin_reject, jam});
      end
    end
    check_counts("reset_mid");
    run_coin(2'b10, 9, 12, "after_reset_quarter");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) run_coin(2'b10, 7, 12, "saturation");
    checks++;
    if (s_quarter_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_final got %0d exp 3", s_quarter_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_coin(2'b10, 6, 12, "b2b_q");
    run_coin(2'b01, 6, 12, "b2b_d");
    run_coin(2'b11, 6, 12, "b2b_x");
    run_coin(2'b01, 6, 12, "b2b_d2");
  endtask

  task automatic test_random();
    logic [1:0] pat;
    int len;
    for (int i = 0; i < 40; i++) begin
      pat = 2'($urandom_range(1, 3));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 30);
      run_coin(pat, len, $urandom_range(12, 20), "random");
    end
  endtask

  initial begin
    test_reset();
    test_clean_quarter();
    test_glitch();
    test_ambiguous();
    test_jam();
    test_reset_mid_qualify();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
